// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way write-back cache: FSM state encoding,
// address-field width derivation and the byte merge used by strobed stores.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRespond,
    StWriteback,
    StRefill,
    StFlushScan,
    StFlushWb
  } cache_state_e;

  function automatic int unsigned index_width(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned word_off_width(input int unsigned words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int unsigned tag_width(input int unsigned address_width,
                                            input int unsigned num_sets,
                                            input int unsigned words_per_block);
    return address_width - $clog2(num_sets) - $clog2(words_per_block) - 2;
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/cache_wb_nway_if.sv
// CPU request/response and main-memory block handshake of the N-way cache.
// The cache uses the slave modport; the core/memory side uses master.
interface cache_wb_nway_if #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4
);
  logic                                 read;
  logic                                 write;
  logic [ADDRESS_WIDTH-1:0]             address;
  logic [WORD_SIZE-1:0]                 write_data;
  logic [WORD_SIZE/8-1:0]               write_strobe;
  logic                                 flush;
  logic [WORD_SIZE-1:0]                 read_data;
  logic                                 ready;
  logic                                 flush_done;
  logic                                 mem_req;
  logic                                 mem_we;
  logic [ADDRESS_WIDTH-1:0]             mem_address;
  logic [WORD_SIZE*WORDS_PER_BLOCK-1:0] mem_wdata;
  logic [WORD_SIZE*WORDS_PER_BLOCK-1:0] mem_rdata;
  logic                                 mem_ready;

  modport slave (
    input  read, write, address, write_data, write_strobe, flush, mem_rdata, mem_ready,
    output read_data, ready, flush_done, mem_req, mem_we, mem_address, mem_wdata
  );

  modport master (
    output read, write, address, write_data, write_strobe, flush, mem_rdata, mem_ready,
    input  read_data, ready, flush_done, mem_req, mem_we, mem_address, mem_wdata
  );
endinterface

// File: rtl/cache_way_array.sv
// One way of the cache: tag/data storage with combinational read at i_index,
// line fill, strobed word write, and async-cleared valid/dirty bits.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int unsigned NUM_SETS        = 256,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned TAG_WIDTH       = 22,
  parameter int unsigned WORD_SIZE       = 32,
  localparam int unsigned IndexW = index_width(NUM_SETS),
  localparam int unsigned OffW   = word_off_width(WORDS_PER_BLOCK),
  localparam int unsigned LineW  = WORD_SIZE * WORDS_PER_BLOCK,
  localparam int unsigned StrbW  = WORD_SIZE / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IndexW-1:0]    i_index,
  output logic                 o_valid,
  output logic                 o_dirty,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [LineW-1:0]     o_line,
  input  logic                 i_fill_en,
  input  logic [TAG_WIDTH-1:0] i_fill_tag,
  input  logic [LineW-1:0]     i_fill_line,
  input  logic                 i_wr_en,
  input  logic [OffW-1:0]      i_wr_word_off,
  input  logic [WORD_SIZE-1:0] i_wr_data,
  input  logic [StrbW-1:0]     i_wr_strobe,
  input  logic                 i_clean_en
);

  logic [NUM_SETS-1:0]  r_valid;
  logic [NUM_SETS-1:0]  r_dirty;
  logic [TAG_WIDTH-1:0] r_tag  [NUM_SETS];
  logic [WORD_SIZE-1:0] r_data [NUM_SETS][WORDS_PER_BLOCK];
  logic [WORD_SIZE-1:0] w_merged;

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];

  for (genvar w = 0; w < WORDS_PER_BLOCK; w++) begin : g_line
    assign o_line[w*WORD_SIZE +: WORD_SIZE] = r_data[i_index][w];
  end

  always_comb begin
    w_merged = '0;
    for (int b = 0; b < StrbW; b++) begin
      w_merged[b*8 +: 8] = merge_byte(r_data[i_index][i_wr_word_off][b*8 +: 8],
                                      i_wr_data[b*8 +: 8], i_wr_strobe[b]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_index] <= 1'b1;
    end else if (i_clean_en) begin
      r_dirty[i_index] <= 1'b0;
    end
  end

  // Tag and data storage carry no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_index] <= i_fill_tag;
      for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
        r_data[i_index][w] <= i_fill_line[w*WORD_SIZE +: WORD_SIZE];
      end
    end else if (i_wr_en) begin
      r_data[i_index][i_wr_word_off] <= w_merged;
    end
  end

endmodule

// File: rtl/cache_wb_nway.sv
// N-way set-associative write-back, write-allocate cache: FSM, hit/victim
// selection, per-set round-robin victim pointers and the flush walker.
module cache_wb_nway
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS        = 4,
  parameter int unsigned NUM_SETS        = 256,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned WORD_SIZE       = 32
) (
  input  logic            clk,
  input  logic            reset,
  cache_wb_nway_if.slave  bus
);

  localparam int unsigned IndexW = index_width(NUM_SETS);
  localparam int unsigned OffW   = word_off_width(WORDS_PER_BLOCK);
  localparam int unsigned TagW   = tag_width(ADDRESS_WIDTH, NUM_SETS, WORDS_PER_BLOCK);
  localparam int unsigned WayW   = $clog2(NUM_WAYS);
  localparam int unsigned LineW  = WORD_SIZE * WORDS_PER_BLOCK;

  cache_state_e r_state, w_state_nxt;

  logic                     r_ready, w_ready_nxt;
  logic                     r_flush_done, w_flush_done_nxt;
  logic                     r_mem_req, w_mem_req_nxt;
  logic                     r_mem_we, w_mem_we_nxt;
  logic [ADDRESS_WIDTH-1:0] r_mem_address, w_mem_address_nxt;
  logic [LineW-1:0]         r_mem_wdata, w_mem_wdata_nxt;
  logic [WORD_SIZE-1:0]     r_read_data, w_read_data_nxt;
  logic [WayW-1:0]          r_victim_way, w_victim_way_nxt;
  logic                     r_victim_was_valid, w_victim_was_valid_nxt;
  logic [IndexW+WayW-1:0]   r_flush_cnt, w_flush_cnt_nxt;
  logic [WayW-1:0]          r_victim_ptr [NUM_SETS];
  logic                     w_ptr_adv;

  logic [TagW-1:0]   w_tag_in;
  logic [IndexW-1:0] w_set_in;
  logic [OffW-1:0]   w_off_in;
  logic [IndexW-1:0] w_index;
  logic [WayW-1:0]   w_flush_way;
  logic              w_flush_mode;

  logic [NUM_WAYS-1:0] w_valid, w_dirty, w_fill_en, w_wr_en, w_clean_en;
  logic [TagW-1:0]     w_tag  [NUM_WAYS];
  logic [LineW-1:0]    w_line [NUM_WAYS];

  logic                 w_hit;
  logic [WayW-1:0]      w_hit_way;
  logic [WayW-1:0]      w_victim;
  logic [WORD_SIZE-1:0] w_hit_word;

  assign w_tag_in     = bus.address[ADDRESS_WIDTH-1 -: TagW];
  assign w_set_in     = bus.address[OffW+2 +: IndexW];
  assign w_off_in     = bus.address[2 +: OffW];
  assign w_flush_mode = (r_state == StFlushScan) || (r_state == StFlushWb);
  assign w_flush_way  = r_flush_cnt[WayW-1:0];
  // The flush walker owns the array index while flushing; otherwise the CPU address does.
  assign w_index      = w_flush_mode ? r_flush_cnt[WayW +: IndexW] : w_set_in;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    cache_way_array #(
      .NUM_SETS        (NUM_SETS),
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
      .TAG_WIDTH       (TagW),
      .WORD_SIZE       (WORD_SIZE)
    ) u_way (
      .clk           (clk),
      .rst_n         (reset),
      .i_index       (w_index),
      .o_valid       (w_valid[g]),
      .o_dirty       (w_dirty[g]),
      .o_tag         (w_tag[g]),
      .o_line        (w_line[g]),
      .i_fill_en     (w_fill_en[g]),
      .i_fill_tag    (w_tag_in),
      .i_fill_line   (bus.mem_rdata),
      .i_wr_en       (w_wr_en[g]),
      .i_wr_word_off (w_off_in),
      .i_wr_data     (bus.write_data),
      .i_wr_strobe   (bus.write_strobe),
      .i_clean_en    (w_clean_en[g])
    );
  end

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = r_victim_ptr[w_set_in];
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (w_valid[i] && (w_tag[i] == w_tag_in)) begin
        w_hit     = 1'b1;
        w_hit_way = WayW'(i);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!w_valid[i]) w_victim = WayW'(i);
    end
  end

  assign w_hit_word = w_line[w_hit_way][w_off_in*WORD_SIZE +: WORD_SIZE];

  always_comb begin
    w_state_nxt            = r_state;
    w_ready_nxt            = 1'b0;
    w_flush_done_nxt       = 1'b0;
    w_mem_req_nxt          = r_mem_req;
    w_mem_we_nxt           = r_mem_we;
    w_mem_address_nxt      = r_mem_address;
    w_mem_wdata_nxt        = r_mem_wdata;
    w_read_data_nxt        = r_read_data;
    w_victim_way_nxt       = r_victim_way;
    w_victim_was_valid_nxt = r_victim_was_valid;
    w_flush_cnt_nxt        = r_flush_cnt;
    w_fill_en              = '0;
    w_wr_en                = '0;
    w_clean_en             = '0;
    w_ptr_adv              = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.flush) begin
          w_flush_cnt_nxt = '0;
          w_state_nxt     = StFlushScan;
        end else if (bus.write || bus.read) begin
          if (w_hit) begin
            if (bus.write) w_wr_en[w_hit_way] = 1'b1;
            else           w_read_data_nxt    = w_hit_word;
            w_ready_nxt = 1'b1;
            w_state_nxt = StRespond;
          end else begin
            w_victim_way_nxt       = w_victim;
            w_victim_was_valid_nxt = w_valid[w_victim];
            w_mem_req_nxt          = 1'b1;
            if (w_valid[w_victim] && w_dirty[w_victim]) begin
              w_mem_we_nxt      = 1'b1;
              w_mem_address_nxt = {w_tag[w_victim], w_set_in, {(OffW+2){1'b0}}};
              w_mem_wdata_nxt   = w_line[w_victim];
              w_state_nxt       = StWriteback;
            end else begin
              w_mem_we_nxt      = 1'b0;
              w_mem_address_nxt = {w_tag_in, w_set_in, {(OffW+2){1'b0}}};
              w_state_nxt       = StRefill;
            end
          end
        end
      end
      StRespond: w_state_nxt = StIdle;
      StWriteback: begin
        if (bus.mem_ready) begin
          w_mem_we_nxt      = 1'b0;
          w_mem_address_nxt = {w_tag_in, w_set_in, {(OffW+2){1'b0}}};
          w_state_nxt       = StRefill;
        end
      end
      StRefill: begin
        if (bus.mem_ready) begin
          w_fill_en[r_victim_way] = 1'b1;
          w_ptr_adv               = r_victim_was_valid;
          w_mem_req_nxt           = 1'b0;
          w_state_nxt             = StIdle;
        end
      end
      StFlushScan: begin
        if (w_valid[w_flush_way] && w_dirty[w_flush_way]) begin
          w_mem_req_nxt     = 1'b1;
          w_mem_we_nxt      = 1'b1;
          w_mem_address_nxt = {w_tag[w_flush_way], w_index, {(OffW+2){1'b0}}};
          w_mem_wdata_nxt   = w_line[w_flush_way];
          w_state_nxt       = StFlushWb;
        end else if (&r_flush_cnt) begin
          w_flush_done_nxt = 1'b1;
          w_state_nxt      = StIdle;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + 1'b1;
        end
      end
      StFlushWb: begin
        // Line becomes clean, so the rescan of this slot advances past it.
        if (bus.mem_ready) begin
          w_clean_en[w_flush_way] = 1'b1;
          w_mem_req_nxt           = 1'b0;
          w_state_nxt             = StFlushScan;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state            <= StIdle;
      r_ready            <= 1'b0;
      r_flush_done       <= 1'b0;
      r_mem_req          <= 1'b0;
      r_mem_we           <= 1'b0;
      r_mem_address      <= '0;
      r_mem_wdata        <= '0;
      r_read_data        <= '0;
      r_victim_way       <= '0;
      r_victim_was_valid <= 1'b0;
      r_flush_cnt        <= '0;
      for (int s = 0; s < NUM_SETS; s++) r_victim_ptr[s] <= '0;
    end else begin
      r_state            <= w_state_nxt;
      r_ready            <= w_ready_nxt;
      r_flush_done       <= w_flush_done_nxt;
      r_mem_req          <= w_mem_req_nxt;
      r_mem_we           <= w_mem_we_nxt;
      r_mem_address      <= w_mem_address_nxt;
      r_mem_wdata        <= w_mem_wdata_nxt;
      r_read_data        <= w_read_data_nxt;
      r_victim_way       <= w_victim_way_nxt;
      r_victim_was_valid <= w_victim_was_valid_nxt;
      r_flush_cnt        <= w_flush_cnt_nxt;
      if (w_ptr_adv) r_victim_ptr[w_set_in] <= r_victim_way + 1'b1;
    end
  end

  assign bus.read_data   = r_read_data;
  assign bus.ready       = r_ready;
  assign bus.flush_done  = r_flush_done;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_cache_wb_nway.sv
// Directed bench for cache_wb_nway (4 ways, 16 sets, 4-word lines) with a
// latency-programmable block memory that logs every transfer.
module tb_cache_wb_nway;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 1;

  cache_wb_nway_if #(.ADDRESS_WIDTH(32), .WORD_SIZE(32), .WORDS_PER_BLOCK(4)) bus ();

  cache_wb_nway #(
    .NUM_WAYS        (4),
    .NUM_SETS        (16),
    .WORDS_PER_BLOCK (4),
    .ADDRESS_WIDTH   (32),
    .WORD_SIZE       (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [127:0] data;
  } xfer_t;

  xfer_t        log_q[$];
  bit   [127:0] mem [int unsigned];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers mem_req after lat sampled cycles with a one-cycle mem_ready.
  initial begin : responder
    int cnt;
    xfer_t x;
    cnt           = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
      end else if (reset && bus.mem_req) begin
        cnt++;
        if (cnt >= lat) begin
          cnt    = 0;
          x.we   = bus.mem_we;
          x.addr = bus.mem_address;
          x.data = bus.mem_wdata;
          if (bus.mem_we) mem[bus.mem_address] = bus.mem_wdata;
          else            bus.mem_rdata        = mem[bus.mem_address];
          log_q.push_back(x);
          bus.mem_ready = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic cpu_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rdata, output int cyc);
    bus.read         = rd;
    bus.write        = wr;
    bus.address      = a;
    bus.write_data   = d;
    bus.write_strobe = s;
    cyc              = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.ready && cyc < 200);
    rdata = bus.read_data;
    if (!bus.ready) cyc = -1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    log_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    total++; if (bus.flush_done !== 1'b0) begin bad++; $display("FAIL reset_flush_done got %b want 0", bus.flush_done); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    total++; if (bus.mem_address !== 32'h0) begin bad++; $display("FAIL reset_mem_address got %h want 0", bus.mem_address); end
    total++; if (bus.mem_wdata !== 128'h0) begin bad++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
    total++; if (bus.read_data !== 32'h0) begin bad++; $display("FAIL reset_read_data got %h want 0", bus.read_data); end
  endtask

  task automatic test_cold_read();
    logic [31:0] rd;
    int          cyc;
    lat = 1;
    cpu_access(1, 0, 32'h0000_0104, 32'h0, 4'h0, rd, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL cold_latency got %0d want 3", cyc); end
    total++; if (rd !== 32'h0000_00A1) begin bad++; $display("FAIL cold_data got %h want 000000a1", rd); end
    total++; if (log_q.size() !== 1) begin bad++; $display("FAIL cold_xfers got %0d want 1", log_q.size()); end
    if (log_q.size() > 0) begin
      total++; if (log_q[0].we !== 1'b0 || log_q[0].addr !== 32'h0000_0100) begin
        bad++; $display("FAIL cold_fill got we=%b addr=%h want we=0 addr=00000100", log_q[0].we, log_q[0].addr);
      end
    end
    cpu_access(1, 0, 32'h0000_0104, 32'h0, 4'h0, rd, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL hit_latency got %0d want 1", cyc); end
    total++; if (rd !== 32'h0000_00A1) begin bad++; $display("FAIL hit_data got %h want 000000a1", rd); end
    total++; if (log_q.size() !== 1) begin bad++; $display("FAIL hit_xfers got %0d want 1", log_q.size()); end
  endtask

  task automatic test_strobe_write();
    logic [31:0] rd;
    int          cyc;
    cpu_access(0, 1, 32'h0000_0108, 32'hDEAD_BEEF, 4'b0011, rd, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL wr_latency got %0d want 1", cyc); end
    cpu_access(1, 0, 32'h0000_0108, 32'h0, 4'h0, rd, cyc);
    total++; if (rd !== 32'h0000_BEEF) begin bad++; $display("FAIL wr_low_half got %h want 0000beef", rd); end
    // read and write together behave as a write
    cpu_access(1, 1, 32'h0000_010C, 32'h1234_5655, 4'b0001, rd, cyc);
    cpu_access(1, 0, 32'h0000_010C, 32'h0, 4'h0, rd, cyc);
    total++; if (rd !== 32'h0000_0055) begin bad++; $display("FAIL rw_as_write got %h want 00000055", rd); end
    cpu_access(0, 1, 32'h0000_010C, 32'hAABB_CCDD, 4'b1100, rd, cyc);
    cpu_access(1, 0, 32'h0000_010C, 32'h0, 4'h0, rd, cyc);
    total++; if (rd !== 32'hAABB_0055) begin bad++; $display("FAIL wr_high_half got %h want aabb0055", rd); end
    total++; if (log_q.size() !== 1) begin bad++; $display("FAIL wr_no_traffic got %0d want 1", log_q.size()); end
  endtask

  task automatic test_eviction();
    logic [31:0] rd;
    int          cyc;
    do_reset();
    cpu_access(0, 1, 32'h0000_0000, 32'h1122_3344, 4'hF, rd, cyc);
    cpu_access(1, 0, 32'h0000_0100, 32'h0, 4'h0, rd, cyc);
    cpu_access(1, 0, 32'h0000_0200, 32'h0, 4'h0, rd, cyc);
    cpu_access(1, 0, 32'h0000_0300, 32'h0, 4'h0, rd, cyc);
    total++; if (log_q.size() !== 4) begin bad++; $display("FAIL evict_fills got %0d want 4", log_q.size()); end
    log_q.delete();
    cpu_access(1, 0, 32'h0000_0400, 32'h0, 4'h0, rd, cyc);
    total++; if (rd !== 32'h0400_0000) begin bad++; $display("FAIL evict_data got %h want 04000000", rd); end
    total++; if (log_q.size() !== 2) begin bad++; $display("FAIL evict_xfers got %0d want 2", log_q.size()); end
    if (log_q.size() == 2) begin
      total++; if (log_q[0].we !== 1'b1 || log_q[0].addr !== 32'h0) begin
        bad++; $display("FAIL evict_wb got we=%b addr=%h want we=1 addr=00000000", log_q[0].we, log_q[0].addr);
      end
      total++; if (log_q[0].data !== {32'h3, 32'h2, 32'h1, 32'h1122_3344}) begin
        bad++; $display("FAIL evict_wb_data got %h want 00000003000000020000000111223344", log_q[0].data);
      end
      total++; if (log_q[1].we !== 1'b0 || log_q[1].addr !== 32'h0000_0400) begin
        bad++; $display("FAIL evict_fill got we=%b addr=%h want we=0 addr=00000400", log_q[1].we, log_q[1].addr);
      end
    end
    // Pointer now at way 1 (0x100): 0x500 replaces it cleanly, 0x300 survives.
    log_q.delete();
    cpu_access(1, 0, 32'h0000_0500, 32'h0, 4'h0, rd, cyc);
    total++; if (log_q.size() !== 1) begin bad++; $display("FAIL rr_clean_victim got %0d want 1", log_q.size()); end
    cpu_access(1, 0, 32'h0000_0300, 32'h0, 4'h0, rd, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL rr_keep_300 got %0d want 1", cyc); end
    cpu_access(1, 0, 32'h0000_0100, 32'h0, 4'h0, rd, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL rr_evicted_100 got %0d want 3", cyc); end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    int          cyc;
    int          pulses;
    do_reset();
    cpu_access(0, 1, 32'h0000_0020, 32'hCAFE_0002, 4'hF, rd, cyc);
    cpu_access(0, 1, 32'h0000_0050, 32'hCAFE_0005, 4'hF, rd, cyc);
    log_q.delete();
    for (int rep = 0; rep < 2; rep++) begin
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      pulses    = 0;
      for (int c = 0; c < 300; c++) begin
        @(posedge clk);
        #1;
        if (bus.flush_done) pulses++;
      end
      total++; if (pulses !== 1) begin bad++; $display("FAIL flush_done_pulses got %0d want 1", pulses); end
    end
    total++; if (log_q.size() !== 2) begin bad++; $display("FAIL flush_wbs got %0d want 2", log_q.size()); end
    if (log_q.size() == 2) begin
      total++; if (log_q[0].we !== 1'b1 || log_q[0].addr !== 32'h0000_0020) begin
        bad++; $display("FAIL flush_wb0 got we=%b addr=%h want we=1 addr=00000020", log_q[0].we, log_q[0].addr);
      end
      total++; if (log_q[0].data !== {32'h0020_0003, 32'h0020_0002, 32'h0020_0001, 32'hCAFE_0002}) begin
        bad++; $display("FAIL flush_wb0_data got %h want 002000030020000200200001cafe0002", log_q[0].data);
      end
      total++; if (log_q[1].we !== 1'b1 || log_q[1].addr !== 32'h0000_0050) begin
        bad++; $display("FAIL flush_wb1 got we=%b addr=%h want we=1 addr=00000050", log_q[1].we, log_q[1].addr);
      end
    end
    cpu_access(1, 0, 32'h0000_0020, 32'h0, 4'h0, rd, cyc);
    total++; if (cyc !== 1 || rd !== 32'hCAFE_0002) begin
      bad++; $display("FAIL flush_hit_20 got cyc=%0d data=%h want cyc=1 data=cafe0002", cyc, rd);
    end
    cpu_access(1, 0, 32'h0000_0050, 32'h0, 4'h0, rd, cyc);
    total++; if (cyc !== 1 || rd !== 32'hCAFE_0005) begin
      bad++; $display("FAIL flush_hit_50 got cyc=%0d data=%h want cyc=1 data=cafe0005", cyc, rd);
    end
    total++; if (log_q.size() !== 2) begin bad++; $display("FAIL flush_hit_traffic got %0d want 2", log_q.size()); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd;
    int          cyc;
    do_reset();
    lat         = 100;
    bus.read    = 1'b1;
    bus.address = 32'h0000_0104;
    cyc         = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.mem_req && cyc < 10);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rst_refill_req got %b want 1", bus.mem_req); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_async_req got %b want 0", bus.mem_req); end
    bus.read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    log_q.delete();
    cpu_access(1, 0, 32'h0000_0104, 32'h0, 4'h0, rd, cyc);
    total++; if (cyc !== 3 || log_q.size() !== 1) begin
      bad++; $display("FAIL rst_remiss got cyc=%0d xfers=%0d want cyc=3 xfers=1", cyc, log_q.size());
    end
    total++; if (rd !== 32'h0000_00A1) begin bad++; $display("FAIL rst_remiss_data got %h want 000000a1", rd); end
  endtask

  task automatic test_stall();
    int stable;
    int cyc;
    do_reset();
    lat         = 21;
    stable      = 1;
    bus.read    = 1'b1;
    bus.address = 32'h0000_0200;
    cyc         = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc <= 21 && (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 ||
                        bus.mem_address !== 32'h0000_0200 || bus.ready !== 1'b0)) stable = 0;
    end while (!bus.ready && cyc < 100);
    total++; if (stable !== 1) begin bad++; $display("FAIL stall_stable got %0d want 1", stable); end
    total++; if (cyc !== 23) begin bad++; $display("FAIL stall_latency got %0d want 23", cyc); end
    total++; if (bus.read_data !== 32'h0200_0000) begin bad++; $display("FAIL stall_data got %h want 02000000", bus.read_data); end
    bus.read = 1'b0;
    lat      = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    reset            = 1'b0;
    bus.read         = 1'b0;
    bus.write        = 1'b0;
    bus.flush        = 1'b0;
    bus.address      = '0;
    bus.write_data   = '0;
    bus.write_strobe = '0;
    for (int unsigned i = 0; i < 128; i++) begin
      a = i * 16;
      mem[a] = {a[15:0], 16'd3, a[15:0], 16'd2, a[15:0], 16'd1, a[15:0], 16'd0};
    end
    mem[32'h100] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    test_reset();
    test_cold_read();
    test_strobe_write();
    test_eviction();
    test_flush();
    test_reset_mid_refill();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
